// File: rtl/adder_nibble_seq_pkg.sv
// Shared constants for the nibble-serial adder sequencer and its 4-bit slice.
package adder_nibble_seq_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/adder_nibble_seq_adder4_co.sv
// Purely combinational 4-bit ripple-carry adder slice with carry in/out.
module adder4_co
  import adder_nibble_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic carry;

  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/adder_nibble_seq.sv
// Nibble-serial W-bit adder: one shared 4-bit slice, LSB nibble first,
// carry registered between nibbles, single-cycle done pulse on completion.
module adder_nibble_seq
  import adder_nibble_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIB_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic         co
);

  localparam int CNT_W = $clog2(NIBBLES + 1);

  logic [1:0]       state;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;
  logic [W-1:0]     sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [NIB_W-1:0] slice_s;
  logic             slice_co;
  logic [W-1:0]     sum_next;
  logic             last;

  // Concatenate then drop the low nibble so the shift also works when W == NIB_W.
  function automatic logic [W-1:0] shift_in(input logic [NIB_W-1:0] nib,
                                            input logic [W-1:0]     sr);
    logic [W+NIB_W-1:0] cat;
    cat = {nib, sr};
    return cat[W+NIB_W-1:NIB_W];
  endfunction

  adder4_co u_slice (
    .a  (opa[NIB_W-1:0]),
    .b  (opb[NIB_W-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  assign sum_next = shift_in(slice_s, sum_sr);
  assign last     = (cnt == CNT_W'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      opa    <= '0;
      opb    <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      q      <= '0;
      co     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            opa    <= a;
            opb    <= b;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_sr <= sum_next;
          opa    <= opa >> NIB_W;
          opb    <= opb >> NIB_W;
          carry  <= slice_co;
          cnt    <= cnt + 1'b1;
          // q/co are published only as a complete result.
          if (last) begin
            q     <= sum_next;
            co    <= slice_co;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_adder_nibble_seq.sv
// Directed bench for adder_nibble_seq with NIBBLES=4 (16-bit operands).
module tb_adder_nibble_seq;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic         co;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_nibble_seq #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .co    (co)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation, check the busy window, done position and result.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] eq, input logic eco, input bit garbage);
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy), 1);
    for (int i = 1; i <= N; i++) begin
      if (garbage) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
      if (i < N) begin
        chk({tag, "_busy_run"}, 32'(busy), 1);
        chk({tag, "_done_early"}, 32'(done), 0);
      end else begin
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_done"}, 32'(busy), 0);
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_co"}, 32'(co), 32'(eco));
      end
    end
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_co", 32'(co), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op("ffff_p1", 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("0f0f_garb", 16'h0F0F, 16'h0101, 16'h1010, 1'b0, 1'b1);
    run_op("1234_4321", 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);

    // Second start during RUN must be ignored; q holds until completion.
    a = 16'h0001; b = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ign_q_e1", 32'(q), 32'h5555);
    a = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_q_e2", 32'(q), 32'h5555);
    chk("ign_busy_e2", 32'(busy), 1);
    tick();
    chk("ign_q_e3", 32'(q), 32'h5555);
    chk("ign_done_e3", 32'(done), 0);
    tick();
    chk("ign_done_e4", 32'(done), 1);
    chk("ign_q_e4", 32'(q), 32'h0002);
    chk("ign_co_e4", 32'(co), 0);
    tick();
    chk("ign_done_e5", 32'(done), 0);
    tick();
    chk("ign_noqueue_e6", 32'(busy), 0);

    // Asynchronous reset in the middle of an operation.
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_q", 32'(q), 0);
    chk("mid_rst_co", 32'(co), 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("mid_rst_no_done", 32'(seen), 0);
    run_op("8000_8000", 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0);

    // start held high: accepts every N+2 cycles, done single-cycle pulses.
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("hold_busy", 32'(busy), 32'((c % 6) < 4));
      chk("hold_done", 32'(done), 32'((c % 6) == 4));
      if ((c % 6) == 4) chk("hold_q", 32'(q), 32'h0003);
    end
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("hold_drain_done", 32'(seen), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
